// File: rtl/uart_pkg.sv
// Shared UART types: receive FSM state encoding and default frame geometry.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        RECOVER
    } rx_state_e;

    localparam int DEF_DATA_BITS  = 8;
    localparam int DEF_OVERSAMPLE = 16;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an idle-high serial line; both flops preset to 1.
// Latency 2 clocks; no backpressure.
module uart_sync2 (
    input  logic baud_clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge baud_clk or posedge reset) begin
        if (reset) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_framer.sv
// UART receive framer: oversampled start qualify, mid-bit data sampling, stop check (parity with UART_RX_PARITY_EN).
// Latency: rx_valid ~2 + OVERSAMPLE/2 + (DATA_BITS+P+1)*OVERSAMPLE ticks after the start edge.
// Backpressure: rx_valid held until rx_ack; a frame arriving while still valid is dropped and flags overrun.
module uart_rx_framer
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = DEF_DATA_BITS,
    parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
    input  logic                 baud_clk,
    input  logic                 reset,
    input  logic                 rx_in,
    input  logic                 rx_ack,
    input  logic                 parity_odd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] TICK_MID = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_END = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    rx_state_e            state;
    logic [TW-1:0]        tick;
    logic [BW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 rx_s;
    logic                 stop_sample;
    logic                 commit;

    uart_sync2 u_sync (
        .baud_clk (baud_clk),
        .reset    (reset),
        .d        (rx_in),
        .q        (rx_s)
    );

    assign stop_sample = (state == STOP) && (tick == TICK_END);
    // A frame lands if the holding register is free or being freed this very tick.
    assign commit      = stop_sample && (!rx_valid || rx_ack);

    always_ff @(posedge baud_clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            tick      <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            tick <= (tick == TICK_END) ? '0 : tick + 1'b1;

            if (rx_ack && rx_valid) begin
                rx_valid <= 1'b0;
                overrun  <= 1'b0;
            end

            if (commit) begin
                rx_data   <= shift_reg;
                frame_err <= ~rx_s;
                rx_valid  <= 1'b1;
            end else if (stop_sample) begin
                overrun <= 1'b1;
            end

            case (state)
                IDLE: begin
                    tick <= '0;
                    if (!rx_s) begin
                        state <= START;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (tick == TICK_MID) begin
                        tick <= '0;
                        if (!rx_s) begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    if (tick == TICK_END) begin
                        shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
                        bit_idx   <= bit_idx + 1'b1;
                        if (bit_idx == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end
                end
                PARITY: begin
                    if (tick == TICK_END)
                        state <= STOP;
                end
                STOP: begin
                    if (tick == TICK_END) begin
                        state <= rx_s ? IDLE : RECOVER;
                        busy  <= ~rx_s;
                    end
                end
                RECOVER: begin
                    // Line held low past the stop bit: wait for idle before hunting a new start.
                    tick <= '0;
                    if (rx_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_mis;

    always_ff @(posedge baud_clk or posedge reset) begin
        if (reset) begin
            par_mis    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            if (state == PARITY && tick == TICK_END)
                par_mis <= (^shift_reg) ^ rx_s ^ parity_odd;
            if (commit)
                parity_err <= par_mis;
        end
    end
`else
    logic unused_parity_odd;

    assign unused_parity_odd = parity_odd;
    assign parity_err        = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_framer.sv
// Directed bench for uart_rx_framer: reset, clean frames, glitch, break, overrun, parity, mid-frame reset.
module tb_uart_rx_framer;

    localparam int OS = 16;
`ifdef UART_RX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic       baud_clk = 1'b0;
    logic       reset    = 1'b1;
    logic       rx_in    = 1'b1;
    logic       rx_ack   = 1'b0;
    logic       parity_odd = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       parity_err;
    logic       overrun;
    logic       busy;

    int n_chk  = 0;
    int n_fail = 0;
    int lat    = 0;

    always #5 baud_clk = ~baud_clk;

    uart_rx_framer #(.DATA_BITS(8), .OVERSAMPLE(OS)) dut (
        .baud_clk   (baud_clk),
        .reset      (reset),
        .rx_in      (rx_in),
        .rx_ack     (rx_ack),
        .parity_odd (parity_odd),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) @(negedge baud_clk);
    endtask

    // Even-parity bit for the default parity_odd=0 setting; -1 means no parity bit on the line.
    function automatic int par_of(input logic [7:0] d);
        return (P != 0) ? int'(^d) : -1;
    endfunction

    task automatic send_frame(input logic [7:0] d, input int par, input logic stop_lvl,
                              input int stop_ticks);
        rx_in = 1'b0;
        ticks(OS);
        for (int i = 0; i < 8; i++) begin
            rx_in = d[i];
            ticks(OS);
        end
        if (par >= 0) begin
            rx_in = par[0];
            ticks(OS);
        end
        rx_in = stop_lvl;
        ticks(stop_ticks);
        rx_in = 1'b1;
    endtask

    task automatic ack;
        rx_ack = 1'b1;
        ticks(1);
        rx_ack = 1'b0;
    endtask

    task automatic check_all_zero(input string pfx);
        chk({pfx, "_data"},   32'(rx_data),    32'h0);
        chk({pfx, "_valid"},  32'(rx_valid),   32'h0);
        chk({pfx, "_ferr"},   32'(frame_err),  32'h0);
        chk({pfx, "_perr"},   32'(parity_err), 32'h0);
        chk({pfx, "_ovr"},    32'(overrun),    32'h0);
        chk({pfx, "_busy"},   32'(busy),       32'h0);
    endtask

    initial begin
        ticks(3);
        check_all_zero("rst");
        reset = 1'b0;
        ticks(4);

        // Clean 0x55 frame with latency measured in rising edges from the falling start edge.
        fork
            send_frame(8'h55, par_of(8'h55), 1'b1, OS);
            begin
                lat = 0;
                while (!rx_valid && lat < 400) begin
                    @(posedge baud_clk);
                    #1;
                    lat++;
                end
            end
        join
        chk("lat_window", 32'(lat >= 154 + 16 * P && lat <= 155 + 16 * P), 32'h1);
        chk("f55_data",  32'(rx_data),    32'h55);
        chk("f55_valid", 32'(rx_valid),   32'h1);
        chk("f55_ferr",  32'(frame_err),  32'h0);
        chk("f55_perr",  32'(parity_err), 32'h0);
        chk("f55_ovr",   32'(overrun),    32'h0);
        ack();
        chk("f55_ack_valid", 32'(rx_valid), 32'h0);

        // Short low glitch: qualified out in START.
        rx_in = 1'b0;
        ticks(4);
        rx_in = 1'b1;
        ticks(2);
        chk("glitch_busy_hi", 32'(busy), 32'h1);
        ticks(20);
        chk("glitch_busy_lo", 32'(busy),     32'h0);
        chk("glitch_valid",   32'(rx_valid), 32'h0);

        // 0xA3 with a low stop bit and the line held low: frame error, stays in RECOVER.
        send_frame(8'hA3, par_of(8'hA3), 1'b0, 40);
        chk("brk_data",  32'(rx_data),   32'hA3);
        chk("brk_valid", 32'(rx_valid),  32'h1);
        chk("brk_ferr",  32'(frame_err), 32'h1);
        chk("brk_busy",  32'(busy),      32'h1);
        ticks(6);
        chk("brk_idle",  32'(busy),      32'h0);
        ack();
        chk("brk_ack_ferr_hold", 32'(frame_err), 32'h1);

        // Back-to-back frames without ack: second is dropped.
        send_frame(8'h11, par_of(8'h11), 1'b1, OS);
        send_frame(8'h22, par_of(8'h22), 1'b1, OS);
        chk("ovr_data",  32'(rx_data),   32'h11);
        chk("ovr_flag",  32'(overrun),   32'h1);
        chk("ovr_valid", 32'(rx_valid),  32'h1);
        chk("ovr_ferr",  32'(frame_err), 32'h0);
        ack();
        chk("ovr_ack_valid", 32'(rx_valid), 32'h0);
        chk("ovr_ack_flag",  32'(overrun),  32'h0);
        ack();
        chk("idle_ack_ignored", 32'(rx_valid), 32'h0);

`ifdef UART_RX_PARITY_EN
        parity_odd = 1'b0;
        send_frame(8'hA5, 1, 1'b1, OS);
        chk("par_even_bad", 32'(parity_err), 32'h1);
        chk("par_even_bad_data", 32'(rx_data), 32'hA5);
        ack();
        send_frame(8'hA5, 0, 1'b1, OS);
        chk("par_even_ok", 32'(parity_err), 32'h0);
        ack();
        parity_odd = 1'b1;
        send_frame(8'hA5, 1, 1'b1, OS);
        chk("par_odd_ok", 32'(parity_err), 32'h0);
        ack();
        parity_odd = 1'b0;
`endif

        // Leave a frame pending, then reset in the middle of a 0xFF frame.
        send_frame(8'h5A, par_of(8'h5A), 1'b1, OS);
        chk("pre_rst_valid", 32'(rx_valid), 32'h1);
        rx_in = 1'b0;
        ticks(OS);
        rx_in = 1'b1;
        ticks(40);
        chk("mid_busy", 32'(busy), 32'h1);
        reset = 1'b1;
        ticks(2);
        check_all_zero("midrst");
        reset = 1'b0;
        ticks(4);
        send_frame(8'h3C, par_of(8'h3C), 1'b1, OS);
        chk("post_rst_data",  32'(rx_data),   32'h3C);
        chk("post_rst_valid", 32'(rx_valid),  32'h1);
        chk("post_rst_ferr",  32'(frame_err), 32'h0);
        chk("post_rst_ovr",   32'(overrun),   32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
